pe_dbuf: RTL and testbench

Next-generation systolic-array processing element with a parametrised datapath. Weights are double-buffered: a shadow weight loads while the active weight keeps computing, and a propagated swap strobe flips them with no bubble. The MAC is gated by valid, supports optional saturation, and raises a sticky overflow flag. The block tiles into the same row/column array as the current PE. Operands, weight bus, enable/ID, swap, address and valid all forward with 1-cycle latency.

---
 rtl/pe_dbuf.sv | 112 +++++++++++
 tb/tb_pe_dbuf.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pe_dbuf.sv
// Systolic-array PE with a double-buffered weight: the shadow loads while the active weight computes.
// Operands and tags forward with one cycle of latency. The valid-gated MAC can saturate and sets a sticky overflow flag.
module pe_dbuf #(
   parameter int unsigned BIT_DATA   = 8,
   parameter int unsigned BIT_PSUM   = 24,
   parameter int unsigned BIT_ROW_ID = 4,
   parameter int unsigned BIT_ADDR   = 8,
   parameter int unsigned BIT_VALID  = 1,
   parameter bit          SATURATE   = 1'b1
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [BIT_ROW_ID-1:0] Row_ID,
   input  logic [BIT_DATA-1:0]   Data_I_In,
   output logic [BIT_DATA-1:0]   Data_I_Out,
   input  logic [BIT_DATA-1:0]   Data_W_In,
   output logic [BIT_DATA-1:0]   Data_W_Out,
   input  logic                  EN_W_In,
   output logic                  EN_W_Out,
   input  logic [BIT_ROW_ID-1:0] EN_ID_In,
   output logic [BIT_ROW_ID-1:0] EN_ID_Out,
   input  logic                  Swap_In,
   output logic                  Swap_Out,
   input  logic [BIT_PSUM-1:0]   Psum_In,
   output logic [BIT_PSUM-1:0]   Psum_Out,
   input  logic [BIT_ADDR-1:0]   Addr_P_In,
   output logic [BIT_ADDR-1:0]   Addr_P_Out,
   input  logic [BIT_VALID-1:0]  Valid_P_In,
   output logic [BIT_VALID-1:0]  Valid_P_Out,
   input  logic                  Clr_Ovf,
   output logic                  Ovf_Out
);

   if (BIT_PSUM < 2 * BIT_DATA) begin : g_bad_psum
      $error("pe_dbuf: BIT_PSUM must be >= 2*BIT_DATA");
   end

   localparam logic [BIT_ROW_ID-1:0] ID_NONE = '1;

   logic signed [BIT_DATA-1:0]   w_sh_q, w_sh_d;
   logic signed [BIT_DATA-1:0]   w_act_q, w_act_d;
   logic signed [2*BIT_DATA-1:0] prod;
   logic        [BIT_PSUM:0]     sum;
   logic        [BIT_PSUM-1:0]   result;
   logic        [BIT_PSUM-1:0]   psum_d;
   logic                         wt_hit;
   logic                         mac_valid;
   logic                         ovf;
   logic                         ovf_d;

   always_comb begin
      wt_hit = (EN_ID_In == Row_ID) && (EN_ID_In != ID_NONE);
      w_sh_d = w_sh_q;
      if (wt_hit) begin
         w_sh_d = EN_W_In ? Data_W_In : '0;
      end
      // Swap takes the pre-edge shadow, so a same-edge load lands only in the shadow
      w_act_d = Swap_In ? w_sh_q : w_act_q;

      prod = $signed(Data_I_In) * w_act_q;
      sum  = {{(BIT_PSUM + 1 - 2 * BIT_DATA){prod[2*BIT_DATA-1]}}, prod}
           + {Psum_In[BIT_PSUM-1], Psum_In};
      ovf  = sum[BIT_PSUM] ^ sum[BIT_PSUM-1];

      result = sum[BIT_PSUM-1:0];
      if (ovf && SATURATE) begin
         result = sum[BIT_PSUM] ? {1'b1, {(BIT_PSUM - 1){1'b0}}}
                                : {1'b0, {(BIT_PSUM - 1){1'b1}}};
      end

      mac_valid = |Valid_P_In;
      psum_d    = mac_valid ? result : Psum_In;

      // Set has priority over the clear
      ovf_d = Ovf_Out;
      if (Clr_Ovf) begin
         ovf_d = 1'b0;
      end
      if (mac_valid && ovf) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         w_sh_q      <= '0;
         w_act_q     <= '0;
         Data_I_Out  <= '0;
         Data_W_Out  <= '0;
         EN_W_Out    <= 1'b0;
         EN_ID_Out   <= ID_NONE;
         Swap_Out    <= 1'b0;
         Psum_Out    <= '0;
         Addr_P_Out  <= '0;
         Valid_P_Out <= '0;
         Ovf_Out     <= 1'b0;
      end else begin
         w_sh_q      <= w_sh_d;
         w_act_q     <= w_act_d;
         Data_I_Out  <= Data_I_In;
         Data_W_Out  <= Data_W_In;
         EN_W_Out    <= EN_W_In;
         EN_ID_Out   <= EN_ID_In;
         Swap_Out    <= Swap_In;
         Psum_Out    <= psum_d;
         Addr_P_Out  <= Addr_P_In;
         Valid_P_Out <= Valid_P_In;
         Ovf_Out     <= ovf_d;
      end
   end

endmodule

// File: tb/tb_pe_dbuf.sv
// Directed bench for pe_dbuf: one saturating and one wrapping instance driven from shared inputs.
module tb_pe_dbuf;

   logic        CLK = 1'b0;
   logic        RST;
   logic [3:0]  Row_ID;
   logic [7:0]  Data_I_In, Data_W_In;
   logic        EN_W_In, Swap_In, Clr_Ovf;
   logic [3:0]  EN_ID_In;
   logic [23:0] Psum_In;
   logic [7:0]  Addr_P_In;
   logic [0:0]  Valid_P_In;

   logic [7:0]  s_data_i, s_data_w, w_data_i, w_data_w;
   logic        s_en_w, s_swap, s_ovf, w_en_w, w_swap, w_ovf;
   logic [3:0]  s_en_id, w_en_id;
   logic [23:0] s_psum, w_psum;
   logic [7:0]  s_addr, w_addr;
   logic [0:0]  s_valid, w_valid;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 CLK = ~CLK;

   pe_dbuf #(.SATURATE(1'b1)) dut_sat (
      .CLK(CLK), .RST(RST), .Row_ID(Row_ID),
      .Data_I_In(Data_I_In), .Data_I_Out(s_data_i),
      .Data_W_In(Data_W_In), .Data_W_Out(s_data_w),
      .EN_W_In(EN_W_In), .EN_W_Out(s_en_w),
      .EN_ID_In(EN_ID_In), .EN_ID_Out(s_en_id),
      .Swap_In(Swap_In), .Swap_Out(s_swap),
      .Psum_In(Psum_In), .Psum_Out(s_psum),
      .Addr_P_In(Addr_P_In), .Addr_P_Out(s_addr),
      .Valid_P_In(Valid_P_In), .Valid_P_Out(s_valid),
      .Clr_Ovf(Clr_Ovf), .Ovf_Out(s_ovf)
   );

   pe_dbuf #(.SATURATE(1'b0)) dut_wrap (
      .CLK(CLK), .RST(RST), .Row_ID(Row_ID),
      .Data_I_In(Data_I_In), .Data_I_Out(w_data_i),
      .Data_W_In(Data_W_In), .Data_W_Out(w_data_w),
      .EN_W_In(EN_W_In), .EN_W_Out(w_en_w),
      .EN_ID_In(EN_ID_In), .EN_ID_Out(w_en_id),
      .Swap_In(Swap_In), .Swap_Out(w_swap),
      .Psum_In(Psum_In), .Psum_Out(w_psum),
      .Addr_P_In(Addr_P_In), .Addr_P_Out(w_addr),
      .Valid_P_In(Valid_P_In), .Valid_P_Out(w_valid),
      .Clr_Ovf(Clr_Ovf), .Ovf_Out(w_ovf)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic idle();
      Data_I_In = '0; Data_W_In = '0; EN_W_In = 1'b0; EN_ID_In = 4'hF;
      Swap_In = 1'b0; Psum_In = '0; Addr_P_In = '0; Valid_P_In = '0; Clr_Ovf = 1'b0;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic load(input logic [7:0] w, input logic swap);
      idle();
      EN_W_In = 1'b1; EN_ID_In = 4'h2; Data_W_In = w; Swap_In = swap;
      tick();
   endtask

   task automatic mac(input logic [7:0] d, input logic [23:0] p, input logic swap);
      idle();
      Data_I_In = d; Psum_In = p; Valid_P_In = 1'b1; Swap_In = swap;
      tick();
   endtask

   initial begin
      Row_ID = 4'h2;
      idle();
      RST = 1'b1;
      #12;
      check("rst_psum", s_psum, 0);
      check("rst_en_id", s_en_id, 4'hF);
      check("rst_ovf", s_ovf, 0);
      RST = 1'b0;

      // Double buffer: load 7 into shadow, active stays 0 until swap
      load(8'd7, 1'b0);
      check("fwd_en_w", s_en_w, 1);
      check("fwd_en_id", s_en_id, 4'h2);
      check("fwd_data_w", s_data_w, 8'd7);
      mac(8'd4, 24'd0, 1'b0);
      check("pre_swap_psum", s_psum, 0);
      Addr_P_In = 8'hA5;
      mac(8'd4, 24'd0, 1'b1);
      check("swap_edge_psum", s_psum, 0);
      check("fwd_swap", s_swap, 1);
      check("fwd_data_i", s_data_i, 8'd4);
      check("fwd_valid", s_valid, 1);
      mac(8'd4, 24'd0, 1'b0);
      check("post_swap_psum", s_psum, 24'd28);
      check("swap_out_clear", s_swap, 0);

      // Same-edge load and swap
      load(8'd1, 1'b0);
      load(8'd3, 1'b1);   // act=1, sh=3
      mac(8'd1, 24'd0, 1'b0);
      check("act_is_1", s_psum, 24'd1);
      load(8'd9, 1'b1);   // act=3, sh=9
      mac(8'd1, 24'd0, 1'b1);
      check("act_is_3", s_psum, 24'd3);
      mac(8'd1, 24'd0, 1'b0);
      check("act_is_9", s_psum, 24'd9);

      // ID filtering: shadow stays 9
      idle(); EN_ID_In = 4'hF; tick();
      Row_ID = 4'hF; idle(); EN_ID_In = 4'hF; tick();
      Row_ID = 4'h2;
      idle(); EN_ID_In = 4'h1; tick();
      idle(); Swap_In = 1'b1; tick();
      mac(8'd2, 24'd0, 1'b0);
      check("id_filter_keep", s_psum, 24'd18);
      idle(); EN_ID_In = 4'h2; tick();
      idle(); Swap_In = 1'b1; tick();
      mac(8'd2, 24'd7, 1'b0);
      check("targeted_clear", s_psum, 24'd7);

      // Overflow: 127*127 + 0x7FFFF0 = 8404721
      load(8'd127, 1'b0);
      idle(); Swap_In = 1'b1; tick();
      idle(); Data_I_In = 8'd127; Psum_In = 24'h7FFFF0; Valid_P_In = 1'b1; Clr_Ovf = 1'b1;
      tick();
      check("sat_pos_psum", s_psum, 24'h7FFFFF);
      check("wrap_pos_psum", w_psum, 24'h803EF1);  // -8372495
      check("sat_ovf_set_wins", s_ovf, 1);
      check("wrap_ovf_set_wins", w_ovf, 1);
      idle(); Clr_Ovf = 1'b1; tick();
      check("ovf_clear_sat", s_ovf, 0);
      check("ovf_clear_wrap", w_ovf, 0);
      check("bypass_zero", s_psum, 0);
      // Negative: -128*127 + 0x800000 underflows
      mac(8'h80, 24'h800000, 1'b0);
      check("sat_neg_psum", s_psum, 24'h800000);
      check("wrap_neg_psum", w_psum, 24'h7FC080);
      check("neg_ovf", s_ovf, 1);

      // Valid bypass keeps psum and leaves ovf alone
      idle(); Data_I_In = 8'd127; Psum_In = 24'h7FFFF0; tick();
      check("bypass_psum", s_psum, 24'h7FFFF0);
      check("bypass_ovf_hold1", s_ovf, 1);
      idle(); Clr_Ovf = 1'b1; tick();
      idle(); Data_I_In = 8'd127; Psum_In = 24'h7FFFF0; tick();
      check("bypass_ovf_hold0", s_ovf, 0);
      mac(8'd127, 24'h7FFFF0, 1'b0);
      check("ovf_reset_src", s_ovf, 1);

      // Asynchronous reset mid-stream with W_act=5
      load(8'd5, 1'b0);
      idle(); Swap_In = 1'b1; tick();
      mac(8'd3, 24'd10, 1'b0);
      check("pre_rst_psum", s_psum, 24'd25);
      RST = 1'b1;
      #1;
      check("arst_psum", s_psum, 0);
      check("arst_en_id", s_en_id, 4'hF);
      check("arst_data_i", s_data_i, 0);
      check("arst_valid", s_valid, 0);
      check("arst_ovf", s_ovf, 1'b0);
      #2;
      RST = 1'b0;
      mac(8'd3, 24'd10, 1'b0);
      check("post_rst_psum", s_psum, 24'd10);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
